fighter_anim_controller: RTL and testbench

//  Per-fighter animation sequencer. Picks which sprite sheet (idle/kick/punch/hurt), animation step and

---
 rtl/anim_pkg.sv | 18 +
 rtl/req_edge_latch.sv | 26 ++
 rtl/fighter_anim_controller.sv | 144 ++++++++++++++
 tb/tb_fighter_anim_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// Shared animation types, used by the sequencer, the sprite ROM address mux
// and the hit detector.
package anim_pkg;

  typedef enum logic [1:0] {
    SPR_IDLE  = 2'd0,
    SPR_KICK  = 2'd1,
    SPR_PUNCH = 2'd2,
    SPR_HURT  = 2'd3
  } sprite_t;

  localparam int STEP_W = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/req_edge_latch.sv
// Rising-edge detector feeding a sticky pending flag. A new edge wins over a
// same-cycle clear so that a press coinciding with a frame tick is kept and
// consumed at the following tick.
module req_edge_latch (
  input  logic Clk,
  input  logic Reset_n,
  input  logic req,
  input  logic clr,
  output logic pend
);

  logic req_q;

  // previous-level register and set-dominant pending flag
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      req_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      req_q <= req;
      if (req && !req_q) pend <= 1'b1;
      else if (clr)      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/fighter_anim_controller.sv
// Per-fighter animation sequencer. Selects sprite sheet, animation step and
// palette bank for the next video frame; all visible changes land on
// frame_tick so a frame never tears mid-scan.
module fighter_anim_controller
  import anim_pkg::*;
#(
  parameter int HOLD_FRAMES  = 4,
  parameter int ATTACK_STEPS = 3,
  parameter int ATTACK_STEP  = 1,
  parameter int HURT_FRAMES  = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              kick_req,
  input  logic              punch_req,
  input  logic              hit_in,
  output sprite_t           sprite_sel,
  output logic [STEP_W-1:0] anim_step,
  output logic              palette_bank,
  output logic              attack_active,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(max2(HOLD_FRAMES, HURT_FRAMES) + 1);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0]  HURT_LAST = CNT_W'(HURT_FRAMES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ATTACK_STEPS - 1);
  localparam logic [STEP_W-1:0] HIT_STEP  = STEP_W'(ATTACK_STEP);

  sprite_t           state, state_nx;
  logic [STEP_W-1:0] step, step_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              pal, pal_nx;
  logic              done_q, done_nx;

  logic [1:0]        pend_kp;   // [0] kick, [1] punch
  logic              pend_hit;

  // Every tick consumes or discards whatever is pending: in IDLE it is the
  // request being taken, while busy nothing queues.
  req_edge_latch u_req [1:0] (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .req     ({punch_req, kick_req}),
    .clr     ({2{frame_tick}}),
    .pend    (pend_kp)
  );

  // hit is level-captured; a hit coinciding with a tick is held for the next one
  always_ff @(posedge Clk) begin
    if (!Reset_n)        pend_hit <= 1'b0;
    else if (hit_in)     pend_hit <= 1'b1;
    else if (frame_tick) pend_hit <= 1'b0;
  end

  // state register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state  <= SPR_IDLE;
      step   <= '0;
      cnt    <= '0;
      pal    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      step   <= step_nx;
      cnt    <= cnt_nx;
      pal    <= pal_nx;
      done_q <= done_nx;
    end
  end

  // next-state: only a frame tick moves the sequencer; done self-clears
  always_comb begin
    state_nx = state;
    step_nx  = step;
    cnt_nx   = cnt;
    pal_nx   = pal;
    done_nx  = 1'b0;
    if (frame_tick) begin
      case (state)
        SPR_IDLE: begin
          step_nx = '0;
          cnt_nx  = '0;
          pal_nx  = 1'b0;
          if (pend_hit) begin
            state_nx = SPR_HURT;
            pal_nx   = 1'b1;
          end else if (pend_kp[0]) begin
            state_nx = SPR_KICK;
          end else if (pend_kp[1]) begin
            state_nx = SPR_PUNCH;
          end
        end
        SPR_KICK, SPR_PUNCH: begin
          if (pend_hit) begin
            // abort into HURT, no done pulse
            state_nx = SPR_HURT;
            step_nx  = '0;
            cnt_nx   = '0;
            pal_nx   = 1'b1;
          end else if (cnt == HOLD_LAST) begin
            cnt_nx = '0;
            if (step == STEP_LAST) begin
              state_nx = SPR_IDLE;
              step_nx  = '0;
              done_nx  = 1'b1;
            end else begin
              step_nx = step + STEP_W'(1);
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        SPR_HURT: begin
          if (cnt == HURT_LAST) begin
            state_nx = SPR_IDLE;
            cnt_nx   = '0;
            pal_nx   = 1'b0;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
            pal_nx = ~pal;
          end
        end
        default: state_nx = SPR_IDLE;
      endcase
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    sprite_sel    = state;
    anim_step     = step;
    palette_bank  = pal;
    done          = done_q;
    busy          = (state != SPR_IDLE);
    attack_active = ((state == SPR_KICK) || (state == SPR_PUNCH)) && (step == HIT_STEP);
  end

endmodule

// File: tb/tb_fighter_anim_controller.sv
// Directed bench for fighter_anim_controller (HOLD=2, STEPS=3, ATTACK_STEP=1,
// HURT=4, frame_tick roughly every 10 Clk).
module tb_fighter_anim_controller;
  import anim_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              frame_tick = 1'b0;
  logic              kick_req = 1'b0;
  logic              punch_req = 1'b0;
  logic              hit_in = 1'b0;
  sprite_t           sprite_sel;
  logic [STEP_W-1:0] anim_step;
  logic              palette_bank, attack_active, busy, done;

  int vecs = 0;
  int errs = 0;

  // {sprite_sel, anim_step, palette_bank, attack_active, busy, done}
  logic [7:0] obs;
  assign obs = {sprite_sel, anim_step, palette_bank, attack_active, busy, done};

  localparam logic [7:0] O_IDLE = 8'b00_00_0_0_0_0;
  localparam logic [7:0] O_DONE = 8'b00_00_0_0_0_1;
  localparam logic [7:0] K0     = 8'b01_00_0_0_1_0;
  localparam logic [7:0] K1     = 8'b01_01_0_1_1_0;
  localparam logic [7:0] K2     = 8'b01_10_0_0_1_0;
  localparam logic [7:0] P0     = 8'b10_00_0_0_1_0;
  localparam logic [7:0] P1     = 8'b10_01_0_1_1_0;
  localparam logic [7:0] P2     = 8'b10_10_0_0_1_0;
  localparam logic [7:0] H1     = 8'b11_00_1_0_1_0;
  localparam logic [7:0] H0     = 8'b11_00_0_0_1_0;

  fighter_anim_controller #(
    .HOLD_FRAMES  (2),
    .ATTACK_STEPS (3),
    .ATTACK_STEP  (1),
    .HURT_FRAMES  (4)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .kick_req      (kick_req),
    .punch_req     (punch_req),
    .hit_in        (hit_in),
    .sprite_sel    (sprite_sel),
    .anim_step     (anim_step),
    .palette_bank  (palette_bank),
    .attack_active (attack_active),
    .busy          (busy),
    .done          (done)
  );

  always #5 Clk = ~Clk;

  // 9 quiet cycles then one tick cycle; returns at the negedge after the tick edge
  task automatic frame();
    repeat (9) @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic press_kick();
    @(negedge Clk); kick_req = 1'b1;
    repeat (2) @(negedge Clk); kick_req = 1'b0;
  endtask

  task automatic pulse_hit();
    @(negedge Clk); hit_in = 1'b1;
    @(negedge Clk); hit_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    vecs++;
    if (obs !== O_IDLE) begin errs++; $display("FAIL reset_state: got %b want %b", obs, O_IDLE); end
    Reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_kick();
    press_kick();
    frame();
    vecs++;
    if (obs !== K0) begin errs++; $display("FAIL rst_kick_start: got %b want %b", obs, K0); end
    frame();
    @(negedge Clk); Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    vecs++;
    if (obs !== O_IDLE) begin errs++; $display("FAIL rst_mid_kick: got %b want %b", obs, O_IDLE); end
    Reset_n = 1'b1;
    frame();
    vecs++;
    if (obs !== O_IDLE) begin errs++; $display("FAIL rst_no_resume: got %b want %b", obs, O_IDLE); end
    // pending press wiped by reset
    press_kick();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    frame();
    vecs++;
    if (obs !== O_IDLE) begin errs++; $display("FAIL rst_no_replay: got %b want %b", obs, O_IDLE); end
  endtask

  task automatic test_kick_seq();
    logic [7:0] seq [7] = '{K0, K0, K1, K1, K2, K2, O_DONE};
    press_kick();
    for (int i = 0; i < 7; i++) begin
      frame();
      vecs++;
      if (obs !== seq[i]) begin errs++; $display("FAIL kick_seq[%0d]: got %b want %b", i, obs, seq[i]); end
    end
    @(negedge Clk);
    vecs++;
    if (obs !== O_IDLE) begin errs++; $display("FAIL kick_done_1clk: got %b want %b", obs, O_IDLE); end
  endtask

  task automatic test_kick_punch_same();
    logic [7:0] kseq [7] = '{K0, K0, K1, K1, K2, K2, O_DONE};
    logic [7:0] pseq [7] = '{P0, P0, P1, P1, P2, P2, O_DONE};
    @(negedge Clk); kick_req = 1'b1; punch_req = 1'b1;
    repeat (2) @(negedge Clk); kick_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      frame();
      vecs++;
      if (obs !== kseq[i]) begin errs++; $display("FAIL kp_kick[%0d]: got %b want %b", i, obs, kseq[i]); end
    end
    frame();
    vecs++;
    if (obs !== O_IDLE) begin errs++; $display("FAIL punch_held_noretrig: got %b want %b", obs, O_IDLE); end
    @(negedge Clk); punch_req = 1'b0;
    @(negedge Clk); punch_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      frame();
      vecs++;
      if (obs !== pseq[i]) begin errs++; $display("FAIL kp_punch[%0d]: got %b want %b", i, obs, pseq[i]); end
    end
    punch_req = 1'b0;
  endtask

  task automatic test_hit_during_kick();
    logic [7:0] kseq [3] = '{K0, K0, K1};
    logic [7:0] hseq [5] = '{H1, H0, H1, H0, O_DONE};
    press_kick();
    for (int i = 0; i < 3; i++) begin
      frame();
      vecs++;
      if (obs !== kseq[i]) begin errs++; $display("FAIL hk_kick[%0d]: got %b want %b", i, obs, kseq[i]); end
    end
    pulse_hit();
    for (int i = 0; i < 5; i++) begin
      frame();
      vecs++;
      if (obs !== hseq[i]) begin errs++; $display("FAIL hk_hurt[%0d]: got %b want %b", i, obs, hseq[i]); end
    end
    @(negedge Clk);
    vecs++;
    if (obs !== O_IDLE) begin errs++; $display("FAIL hk_done_1clk: got %b want %b", obs, O_IDLE); end
  endtask

  task automatic test_coincident_edge();
    logic [7:0] seq [7] = '{K0, K0, K1, K1, K2, K2, O_DONE};
    repeat (9) @(negedge Clk);
    kick_req = 1'b1; frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    vecs++;
    if (obs !== O_IDLE) begin errs++; $display("FAIL coinc_no_change: got %b want %b", obs, O_IDLE); end
    @(negedge Clk); kick_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      frame();
      vecs++;
      if (obs !== seq[i]) begin errs++; $display("FAIL coinc_seq[%0d]: got %b want %b", i, obs, seq[i]); end
    end
  endtask

  task automatic test_hurt_discard();
    logic [7:0] seq [5] = '{H1, H0, H1, H0, O_DONE};
    pulse_hit();
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 2) press_kick();
      if (i == 4) pulse_hit();
      frame();
      vecs++;
      if (obs !== seq[i]) begin errs++; $display("FAIL hurt_seq[%0d]: got %b want %b", i, obs, seq[i]); end
    end
    frame();
    vecs++;
    if (obs !== O_IDLE) begin errs++; $display("FAIL hurt_no_queue: got %b want %b", obs, O_IDLE); end
    frame();
    vecs++;
    if (obs !== O_IDLE) begin errs++; $display("FAIL hurt_no_queue2: got %b want %b", obs, O_IDLE); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_kick();
    test_kick_seq();
    test_kick_punch_same();
    test_hit_during_kick();
    test_coincident_edge();
    test_hurt_discard();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
